// File: rtl/tcdm_pkg.sv
// Shared types for the TCDM response path: response opcode, response record,
// and the FIFO pointer width helper (one extra wrap bit above the index).
package tcdm_pkg;

    typedef enum logic {
        OPC_STORE = 1'b0,
        OPC_LOAD  = 1'b1
    } opc_e;

    localparam int unsigned TCDM_DW = 32;

    typedef struct packed {
        logic [TCDM_DW-1:0] rdata;
        opc_e               opc;
    } resp_t;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tcdm_resp_fifo.sv
// Response FIFO: DEPTH entries of elem_t, registered storage with the head read
// straight from the entry at the read pointer. Wrap bit in the pointers gives full/empty.
module tcdm_resp_fifo
    import tcdm_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type elem_t = resp_t,
    localparam int unsigned PW = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  elem_t         din,
    input  logic          pop,
    output elem_t         dout,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] count
);

    elem_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[PW-2:0]] <= din;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign count = wr_ptr - rd_ptr;
    assign dout  = mem[rd_ptr[PW-2:0]];

endmodule

// File: rtl/tcdm_pipe_resp.sv
// TCDM bank response pipe: tracks granted requests through the fixed SRAM latency,
// buffers responses in order and hands out credits so every issue has a slot.
module tcdm_pipe_resp
    import tcdm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SRAM_LATENCY = 1,
    parameter int unsigned DEPTH        = 4,
    parameter bit          RESP_STORES  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sram_req_i,
    input  logic                  sram_gnt_i,
    input  logic                  sram_wen_i,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    output logic                  data_r_valid_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                  data_r_opc_o,
    input  logic                  data_r_ready_i,
    output logic                  credit_ok_o,
    output logic                  overflow_o
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        opc_e                  opc;
    } resp_w_t;

    logic                    issue, tracked, accept, pop;
    logic [SRAM_LATENCY-1:0] vld_pipe, wen_pipe;
    logic [CW-1:0]           outstanding;
    resp_w_t                 push_data, head;
    logic                    fifo_full, fifo_empty;
    logic [PW-1:0]           fifo_count;

    assign issue   = sram_req_i & sram_gnt_i;
    assign tracked = issue & (sram_wen_i | RESP_STORES);
    assign accept  = tracked & credit_ok_o;
    assign pop     = data_r_valid_o & data_r_ready_i;

    // Credit is decoded from the registered count only, so a pop frees a slot next cycle.
    assign credit_ok_o = (outstanding < CW'(DEPTH));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe    <= '0;
            wen_pipe    <= '0;
            outstanding <= '0;
            overflow_o  <= 1'b0;
        end else begin
            vld_pipe[0] <= accept;
            wen_pipe[0] <= sram_wen_i;
            for (int i = 1; i < SRAM_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                wen_pipe[i] <= wen_pipe[i-1];
            end
            if (tracked && !credit_ok_o) overflow_o <= 1'b1;
            if (accept && !pop)      outstanding <= outstanding + CW'(1);
            else if (!accept && pop) outstanding <= outstanding - CW'(1);
        end
    end

    // Read data is only looked at when a load reaches the last stage; stores push a zero ack.
    assign push_data.rdata = wen_pipe[SRAM_LATENCY-1] ? sram_rdata_i : '0;
    assign push_data.opc   = opc_e'(wen_pipe[SRAM_LATENCY-1]);

    tcdm_resp_fifo #(
        .DEPTH  (DEPTH),
        .elem_t (resp_w_t)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (vld_pipe[SRAM_LATENCY-1]),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign data_r_valid_o = ~fifo_empty;
    assign data_r_rdata_o = head.rdata;
    assign data_r_opc_o   = head.opc;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(vld_pipe[SRAM_LATENCY-1] && fifo_full && !pop));
            assert (int'(fifo_count) <= int'(outstanding));
        end
    end

endmodule

// File: tb/tb_tcdm_pipe_resp.sv
// Bench for tcdm_pipe_resp: two instances (LAT=1 with store acks, LAT=2 without)
// driven in lockstep, each with an SRAM data model and an in-order response scoreboard.
module tb_tcdm_pipe_resp;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, gnt = 1'b0, wen = 1'b0, ready = 1'b0;
    logic [31:0] ldata = '0;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        opc;
        int          rdy;
    } exp_t;

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int LAT = (k == 0) ? 1 : 2;
        localparam bit RS  = (k == 0);

        logic [31:0] sram_rdata;
        logic [31:0] rdata;
        logic        valid, opc, credit, ovf;
        logic [31:0] dpipe [LAT];
        logic        dvld  [LAT];
        exp_t        q[$];
        int          outst = 0;
        int          mc    = 0;
        bit          ovf_m = 1'b0;

        tcdm_pipe_resp #(
            .DATA_WIDTH   (32),
            .SRAM_LATENCY (LAT),
            .DEPTH        (DEPTH),
            .RESP_STORES  (RS)
        ) dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .sram_req_i     (req),
            .sram_gnt_i     (gnt),
            .sram_wen_i     (wen),
            .sram_rdata_i   (sram_rdata),
            .data_r_valid_o (valid),
            .data_r_rdata_o (rdata),
            .data_r_opc_o   (opc),
            .data_r_ready_i (ready),
            .credit_ok_o    (credit),
            .overflow_o     (ovf)
        );

        // SRAM model: load data appears LAT cycles after issue, junk otherwise.
        initial begin
            sram_rdata = '0;
            for (int i = 0; i < LAT; i++) begin
                dpipe[i] = '0;
                dvld[i]  = 1'b0;
            end
            forever begin
                @(posedge clk);
                for (int i = LAT - 1; i > 0; i--) begin
                    dpipe[i] = dpipe[i-1];
                    dvld[i]  = dvld[i-1];
                end
                dpipe[0] = ldata;
                dvld[0]  = req & gnt & wen;
                #2;
                sram_rdata = dvld[LAT-1] ? dpipe[LAT-1] : $urandom;
            end
        end

        // Scoreboard model, updated on each rising edge from the inputs of the ending cycle.
        initial forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                outst = 0;
                ovf_m = 1'b0;
            end else begin
                bit ok, ev;
                ok = (outst < DEPTH);
                ev = (q.size() > 0) && (q[0].rdy <= mc);
                if (ev && ready) begin
                    void'(q.pop_front());
                    outst--;
                end
                if (req && gnt && (wen || RS)) begin
                    if (ok) begin
                        q.push_back('{wen ? ldata : 32'h0, wen, mc + LAT + 1});
                        outst++;
                    end else begin
                        ovf_m = 1'b1;
                    end
                end
            end
            mc++;
        end

        // Monitor: valid timing, head contents, credit and overflow every cycle.
        initial forever begin
            @(negedge clk);
            if (rst) begin
                total++;
                if (valid !== 1'b0 || credit !== 1'b1 || ovf !== 1'b0 || rdata !== 32'h0 || opc !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_outputs dut%0d t=%0t: valid=%b credit=%b ovf=%b rdata=%h opc=%b want 0 1 0 0 0",
                             k, $time, valid, credit, ovf, rdata, opc);
                end
            end else begin
                bit ev;
                ev = (q.size() > 0) && (q[0].rdy <= mc);
                total++;
                if (valid !== ev) begin
                    bad++;
                    $display("FAIL valid dut%0d cyc=%0d: got %b want %b", k, mc, valid, ev);
                end
                total++;
                if (credit !== (outst < DEPTH)) begin
                    bad++;
                    $display("FAIL credit dut%0d cyc=%0d: got %b want %b", k, mc, credit, outst < DEPTH);
                end
                total++;
                if (ovf !== ovf_m) begin
                    bad++;
                    $display("FAIL overflow dut%0d cyc=%0d: got %b want %b", k, mc, ovf, ovf_m);
                end
                if (ev) begin
                    total++;
                    if (rdata !== q[0].d || opc !== q[0].opc) begin
                        bad++;
                        $display("FAIL head dut%0d cyc=%0d: got %h/%b want %h/%b", k, mc, rdata, opc, q[0].d, q[0].opc);
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        req = 1'b0; gnt = 1'b0; wen = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [31:0] d);
        req = 1'b1; gnt = 1'b1; wen = w; ldata = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        total++;
        if (g[0].valid !== 1'b0 || g[0].credit !== 1'b1 || g[0].ovf !== 1'b0 || g[0].rdata !== 32'h0 ||
            g[1].valid !== 1'b0 || g[1].credit !== 1'b1 || g[1].ovf !== 1'b0 || g[1].rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: valid=%b%b credit=%b%b ovf=%b%b want 00 11 00",
                     g[0].valid, g[1].valid, g[0].credit, g[1].credit, g[0].ovf, g[1].ovf);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_load();
        ready = 1'b0;
        req = 1'b1; gnt = 1'b0; wen = 1'b1; ldata = 32'h1234_5678;
        step();
        req = 1'b0; gnt = 1'b1;
        step();
        idle();
        issue(1'b1, 32'hDEAD_BEEF);
        total++;
        if (g[0].valid !== 1'b0) begin
            bad++; $display("FAIL load_early: valid=%b want 0", g[0].valid);
        end
        step();
        total++;
        if (g[0].valid !== 1'b1 || g[0].rdata !== 32'hDEAD_BEEF || g[0].opc !== 1'b1 || g[1].valid !== 1'b0) begin
            bad++;
            $display("FAIL load_lat1: valid=%b rdata=%h opc=%b lat2_valid=%b want 1 deadbeef 1 0",
                     g[0].valid, g[0].rdata, g[0].opc, g[1].valid);
        end
        step();
        total++;
        if (g[1].valid !== 1'b1 || g[1].rdata !== 32'hDEAD_BEEF || g[1].opc !== 1'b1) begin
            bad++;
            $display("FAIL load_lat2: valid=%b rdata=%h opc=%b want 1 deadbeef 1", g[1].valid, g[1].rdata, g[1].opc);
        end
        ready = 1'b1;
        step(2);
        ready = 1'b0;
    endtask

    task automatic test_store();
        issue(1'b0, 32'h5555_AAAA);
        total++;
        if (g[1].credit !== 1'b1 || g[0].valid !== 1'b0) begin
            bad++; $display("FAIL store_issue: lat2_credit=%b lat1_valid=%b want 1 0", g[1].credit, g[0].valid);
        end
        step();
        total++;
        if (g[0].valid !== 1'b1 || g[0].opc !== 1'b0 || g[0].rdata !== 32'h0 || g[1].valid !== 1'b0) begin
            bad++;
            $display("FAIL store_ack: valid=%b opc=%b rdata=%h noack_valid=%b want 1 0 0 0",
                     g[0].valid, g[0].opc, g[0].rdata, g[1].valid);
        end
        ready = 1'b1;
        step(3);
        ready = 1'b0;
    endtask

    task automatic test_full();
        ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(1'b1, 32'hA000_0000 + i);
        total++;
        if (g[0].credit !== 1'b0 || g[1].credit !== 1'b0) begin
            bad++; $display("FAIL full_credit: got %b%b want 00", g[0].credit, g[1].credit);
        end
        step(2);
        ready = 1'b1;
        step();
        ready = 1'b0;
        total++;
        if (g[0].credit !== 1'b1 || g[1].credit !== 1'b1) begin
            bad++; $display("FAIL credit_after_pop: got %b%b want 11", g[0].credit, g[1].credit);
        end
        ready = 1'b1;
        step(5);
        ready = 1'b0;
    endtask

    task automatic test_overflow();
        int n0 = 0, n1 = 0;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) issue(1'b1, 32'hB000_0000 + i);
        step(3);
        total++;
        if (g[0].ovf !== 1'b1 || g[1].ovf !== 1'b1) begin
            bad++; $display("FAIL overflow_sticky: got %b%b want 11", g[0].ovf, g[1].ovf);
        end
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (g[0].valid) n0++;
            if (g[1].valid) n1++;
            step();
        end
        ready = 1'b0;
        total++;
        if (n0 != DEPTH || n1 != DEPTH) begin
            bad++; $display("FAIL overflow_resp_count: got %0d/%0d want %0d", n0, n1, DEPTH);
        end
    endtask

    task automatic test_mid_reset();
        ready = 1'b0;
        issue(1'b1, 32'hC000_0001);
        issue(1'b1, 32'hC000_0002);
        step(2);
        issue(1'b1, 32'hC000_0003);
        issue(1'b1, 32'hC000_0004);
        rst = 1'b1;
        #1;
        total++;
        if (g[0].valid !== 1'b0 || g[1].valid !== 1'b0 || g[0].credit !== 1'b1 || g[1].credit !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: valid=%b%b credit=%b%b want 00 11", g[0].valid, g[1].valid, g[0].credit, g[1].credit);
        end
        step();
        rst = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (g[0].valid !== 1'b0 || g[1].valid !== 1'b0 || g[0].ovf !== 1'b0 || g[1].ovf !== 1'b0) begin
                bad++;
                $display("FAIL stale_resp: valid=%b%b ovf=%b%b want 00 00", g[0].valid, g[1].valid, g[0].ovf, g[1].ovf);
            end
            step();
        end
        ready = 1'b0;
    endtask

    task automatic test_stream();
        int drops = 0;
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req = 1'b1; gnt = 1'b1; wen = 1'b1; ldata = $urandom;
            if (!g[0].credit || !g[1].credit) drops++;
            step();
        end
        idle();
        total++;
        if (drops != 0) begin
            bad++; $display("FAIL stream_credit: drops=%0d want 0", drops);
        end
        step(4);
        total++;
        if (g[0].valid !== 1'b0 || g[1].valid !== 1'b0) begin
            bad++; $display("FAIL stream_drain: valid=%b%b want 00", g[0].valid, g[1].valid);
        end
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store();
        test_full();
        test_overflow();
        test_mid_reset();
        test_stream();
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
